// File: rtl/parser_defs.sv
// Shared types and wire codes for the market-data byte-stream parser.
package parser_defs;

    localparam int MSG_BYTES = 16;

    localparam logic [7:0] WIRE_ADD     = 8'h41;
    localparam logic [7:0] WIRE_CANCEL  = 8'h58;
    localparam logic [7:0] WIRE_EXECUTE = 8'h45;
    localparam logic [7:0] WIRE_DELETE  = 8'h44;
    localparam logic [7:0] WIRE_BID     = 8'h42;
    localparam logic [7:0] WIRE_ASK     = 8'h53;

    typedef enum logic [1:0] {
        MSG_ADD     = 2'd0,
        MSG_CANCEL  = 2'd1,
        MSG_EXECUTE = 2'd2,
        MSG_DELETE  = 2'd3
    } msg_type_t;

    typedef enum logic {
        ORDER_SIDE_BID = 1'b0,
        ORDER_SIDE_ASK = 1'b1
    } order_side_t;

    typedef struct packed {
        msg_type_t   msg_type;
        logic [7:0]  symbol;
        logic [31:0] order_id;
        order_side_t side;
        logic [31:0] price;
        logic [31:0] quantity;
        logic [7:0]  checksum;
    } parsed_msg_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_DROP    = 2'd2
    } parse_state_t;

endpackage

// File: rtl/wire_decode.sv
// Combinational wire-byte decode into message-type and side enums with valid flags.
module wire_decode
    import parser_defs::*;
(
    input  logic [7:0]  wire_byte,
    output msg_type_t   msg_type,
    output logic        type_ok,
    output order_side_t side,
    output logic        side_ok
);

    always_comb begin
        msg_type = MSG_ADD;
        type_ok  = 1'b1;
        case (wire_byte)
            WIRE_ADD:     msg_type = MSG_ADD;
            WIRE_CANCEL:  msg_type = MSG_CANCEL;
            WIRE_EXECUTE: msg_type = MSG_EXECUTE;
            WIRE_DELETE:  msg_type = MSG_DELETE;
            default:      type_ok  = 1'b0;
        endcase
    end

    always_comb begin
        side    = ORDER_SIDE_BID;
        side_ok = 1'b1;
        case (wire_byte)
            WIRE_BID: side    = ORDER_SIDE_BID;
            WIRE_ASK: side    = ORDER_SIDE_ASK;
            default:  side_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/itch_msg_parser.sv
// Assembles fixed 16-byte order messages, validates type/side/checksum and
// writes good ones into the parsed-message FIFO; bad ones are counted.
module itch_msg_parser
    import parser_defs::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 full,
    output logic                 write_en,
    output parsed_msg_t          parsed_message,
    output logic [ERR_CNT_W-1:0] err_count
);

    parse_state_t state, state_nxt;
    logic [3:0]   byte_idx;
    logic [7:0]   xor_acc;
    logic         bad;

    msg_type_t    dec_type;
    order_side_t  dec_side;
    logic         dec_type_ok;
    logic         dec_side_ok;

    logic accept;
    logic last_byte;
    logic msg_ok;

    wire_decode u_decode (
        .wire_byte (in_data),
        .msg_type  (dec_type),
        .type_ok   (dec_type_ok),
        .side      (dec_side),
        .side_ok   (dec_side_ok)
    );

    assign accept    = in_valid && in_ready;
    assign last_byte = accept && (byte_idx == 4'(MSG_BYTES - 1));
    // xor_acc holds b0..b14 when b15 is on the bus, so it compares directly
    assign msg_ok    = !bad && (xor_acc == in_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        write_en  = 1'b0;
        case (state)
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (last_byte) state_nxt = msg_ok ? ST_EMIT : ST_DROP;
            end
            ST_EMIT: begin
                write_en = !full;
                if (!full) state_nxt = ST_COLLECT;
            end
            ST_DROP: state_nxt = ST_COLLECT;
            default: state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            xor_acc  <= '0;
            bad      <= 1'b0;
        end else if (accept) begin
            byte_idx <= byte_idx + 4'd1;
            xor_acc  <= last_byte ? 8'h00 : (xor_acc ^ in_data);
            if (byte_idx == 4'd0)      bad <= !dec_type_ok;
            else if (byte_idx == 4'd6) bad <= bad || !dec_side_ok;
        end
    end

    // Fields fill positionally; multibyte fields shift in MSB first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parsed_message <= '0;
        end else if (accept) begin
            case (byte_idx)
                4'd0:  parsed_message.msg_type <= dec_type;
                4'd1:  parsed_message.symbol   <= in_data;
                4'd2, 4'd3, 4'd4, 4'd5:
                    parsed_message.order_id <= {parsed_message.order_id[23:0], in_data};
                4'd6:  parsed_message.side     <= dec_side;
                4'd7, 4'd8, 4'd9, 4'd10:
                    parsed_message.price    <= {parsed_message.price[23:0], in_data};
                4'd11, 4'd12, 4'd13, 4'd14:
                    parsed_message.quantity <= {parsed_message.quantity[23:0], in_data};
                default: parsed_message.checksum <= in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else if (state == ST_DROP && err_count != '1)
            err_count <= err_count + ERR_CNT_W'(1);
    end

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: valid, backpressure, malformed, gapped and reset cases.
module tb_itch_msg_parser;
    import parser_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        full = 1'b0;
    logic        in_ready;
    logic        write_en;
    parsed_msg_t parsed_message;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int both_hi = 0;
    parsed_msg_t wq[$];

    itch_msg_parser #(.ERR_CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .full           (full),
        .write_en       (write_en),
        .parsed_message (parsed_message),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (write_en) wq.push_back(parsed_message);
        if (write_en && in_ready) both_hi++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] wmsg(input logic [7:0] t, input logic [7:0] sym,
                                          input logic [31:0] id, input logic [7:0] s,
                                          input logic [31:0] pr, input logic [31:0] q);
        logic [119:0] b;
        logic [7:0]   c;
        b = {t, sym, id, s, pr, q};
        c = 8'h00;
        for (int k = 0; k < 15; k++) c ^= b[8*k +: 8];
        return {b, c};
    endfunction

    function automatic parsed_msg_t pm(input msg_type_t t, input logic [7:0] sym,
                                       input logic [31:0] id, input order_side_t s,
                                       input logic [31:0] pr, input logic [31:0] q,
                                       input logic [7:0] c);
        parsed_msg_t p;
        p.msg_type = t;
        p.symbol   = sym;
        p.order_id = id;
        p.side     = s;
        p.price    = pr;
        p.quantity = q;
        p.checksum = c;
        return p;
    endfunction

    task automatic send(input logic [127:0] m, input int nb, input bit gap);
        int i = 0;
        int guard = 0;
        while (i < nb && guard < 400) begin
            @(negedge clk);
            guard++;
            if (gap && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = m[127-8*i -: 8];
                if (in_ready) i++;
            end
        end
        chk("send_bytes_accepted", i, nb);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input parsed_msg_t e);
        int n = 0;
        while (wq.size() == 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({tag, "_present"}, wq.size() > 0, 1);
        if (wq.size() > 0) chk(tag, wq.pop_front(), e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    logic [127:0] w1, w2, wb, wg, ws, wt, wx, we, wd, wr;

    initial begin
        w1 = {8'h41, 8'h01, 32'h11111111, 8'h42, 32'd1000, 32'd10, 8'hE3};
        w2 = {8'h41, 8'h02, 32'hAAAAAAAA, 8'h53, 32'd1100, 32'd15, 8'h57};

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_write_en", write_en, 0);
        chk("rst_parsed", parsed_message, 0);
        chk("rst_err", err_count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // valid ADD bid
        send(w1, 16, 0);
        expect_write("add_bid", pm(MSG_ADD, 8'h01, 32'h11111111, ORDER_SIDE_BID, 32'd1000, 32'd10, 8'hE3));
        chk("add_err", err_count, 0);

        // backpressure: full held 5 cycles after b15
        full = 1'b1;
        send(w2, 16, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_write_en", write_en, 0);
            chk("bp_parsed_stable", parsed_message,
                pm(MSG_ADD, 8'h02, 32'hAAAAAAAA, ORDER_SIDE_ASK, 32'd1100, 32'd15, 8'h57));
        end
        #2;
        chk("bp_no_write_while_full", wq.size(), 0);
        @(negedge clk);
        full = 1'b0;
        #1;
        chk("bp_write_on_release", write_en, 1);
        expect_write("ask_bp", pm(MSG_ADD, 8'h02, 32'hAAAAAAAA, ORDER_SIDE_ASK, 32'd1100, 32'd15, 8'h57));
        idle(2);
        chk("bp_single_write", wq.size(), 0);

        // bad checksum then an immediate valid message
        wb = wmsg(8'h45, 8'h07, 32'h01020304, 8'h42, 32'd500, 32'd3);
        wb[7:0] = wb[7:0] ^ 8'h01;
        wg = wmsg(8'h58, 8'h08, 32'h0A0B0C0D, 8'h53, 32'd77, 32'd9);
        send(wb, 16, 0);
        send(wg, 16, 0);
        expect_write("after_bad_cks", pm(MSG_CANCEL, 8'h08, 32'h0A0B0C0D, ORDER_SIDE_ASK, 32'd77, 32'd9, wg[7:0]));
        chk("bad_cks_err", err_count, 1);
        idle(2);
        chk("bad_cks_no_extra", wq.size(), 0);

        // bad side then bad type, counted from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ws = wmsg(8'h41, 8'h03, 32'h22222222, 8'h5A, 32'd10, 32'd1);
        wt = wmsg(8'h7F, 8'h04, 32'h33333333, 8'h42, 32'd20, 32'd2);
        send(ws, 16, 0);
        send(wt, 16, 0);
        idle(3);
        chk("bad_side_type_err", err_count, 2);
        chk("bad_side_type_nowrite", wq.size(), 0);

        // gapped input, three back-to-back messages
        wx = wmsg(8'h58, 8'h10, 32'hDEADBEEF, 8'h53, 32'h00012345, 32'd100);
        we = wmsg(8'h45, 8'h11, 32'h00000001, 8'h42, 32'hFFFFFFFF, 32'd0);
        wd = wmsg(8'h44, 8'hFF, 32'h80000000, 8'h53, 32'd0, 32'hFFFFFFFF);
        send(wx, 16, 1);
        send(we, 16, 1);
        send(wd, 16, 1);
        expect_write("gap_cancel", pm(MSG_CANCEL, 8'h10, 32'hDEADBEEF, ORDER_SIDE_ASK, 32'h00012345, 32'd100, wx[7:0]));
        expect_write("gap_execute", pm(MSG_EXECUTE, 8'h11, 32'h00000001, ORDER_SIDE_BID, 32'hFFFFFFFF, 32'd0, we[7:0]));
        expect_write("gap_delete", pm(MSG_DELETE, 8'hFF, 32'h80000000, ORDER_SIDE_ASK, 32'd0, 32'hFFFFFFFF, wd[7:0]));
        chk("gap_err", err_count, 2);

        // reset after byte 7 of a message
        wr = wmsg(8'h41, 8'h20, 32'h55555555, 8'h42, 32'd300, 32'd4);
        send(wr, 8, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_write_en", write_en, 0);
        chk("mid_rst_parsed", parsed_message, 0);
        chk("mid_rst_err", err_count, 0);
        @(negedge clk);
        reset = 1'b1;
        send(w1, 16, 0);
        expect_write("post_rst_msg", pm(MSG_ADD, 8'h01, 32'h11111111, ORDER_SIDE_BID, 32'd1000, 32'd10, 8'hE3));
        idle(3);
        chk("post_rst_single", wq.size(), 0);
        chk("post_rst_err", err_count, 0);

        chk("ready_write_exclusive", both_hi, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/itch_msg_parser.md
# itch_msg_parser

Byte-stream front end of the market data path. Accepts raw fixed-length order messages one byte per cycle, assembles and validates them, and writes one `parsed_msg_t` per good message into the parsed-message FIFO that `order_book` drains through `read_en`/`empty`. It is the writer side of that FIFO. Malformed messages are dropped and counted.

## Interface

Parameters:
- `ERR_CNT_W`, default 16: width of the saturating drop counter.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  parser accepts the byte this cycle.
- `full`  in  1  downstream FIFO full.
- `write_en`  out  1  one-cycle write strobe to the FIFO.
- `parsed_message`  out  `parsed_msg_t`  message written when `write_en` is high.
- `err_count`  out  `ERR_CNT_W`  dropped-message count, saturating.

## Operation

- Wire format is 16 bytes. All multibyte fields are big-endian.
  - b0: type. 0x41 'A' → MSG_ADD, 0x58 'X' → MSG_CANCEL, 0x45 'E' → MSG_EXECUTE, 0x44 'D' → MSG_DELETE.
  - b1: symbol.
  - b2–b5: order_id.
  - b6: side. 0x42 'B' → ORDER_SIDE_BID, 0x53 'S' → ORDER_SIDE_ASK.
  - b7–b10: price.
  - b11–b14: quantity.
  - b15: checksum.
- A byte transfers when `in_valid && in_ready`. A 4-bit byte index counts transfers. Bytes are placed positionally; there is no resync marker.
- The running XOR of b0..b14 must equal b15. Type and side are validated as their bytes arrive.
- The `parsed_message` checksum field carries b15 unchanged.
- States:
  - COLLECT (reset state): accept bytes. When b15 transfers, go to EMIT if the message is valid, else go to DROP.
  - EMIT: `in_ready`=0. `write_en` = !`full`, combinational. Return to COLLECT in the cycle `write_en` is high. While `full`=1, stay in EMIT and hold `parsed_message` stable.
  - DROP: one cycle with `in_ready`=0. Increment `err_count` (saturates at all-ones). Return to COLLECT. Nothing is written.
- A malformed message is always consumed in full (16 bytes) before it is dropped. Framing is never re-aligned inside a message.
- `err_count` counts only messages with a bad checksum, bad type or bad side.

## Timing

- Reset values: `in_ready`=1, `write_en`=0, `parsed_message`=0, `err_count`=0, byte index 0, XOR accumulator 0, state COLLECT.
- Latency: b15 accepted at edge N → `write_en` high in cycle N+1 if `full`=0. The earliest next b0 is accepted at edge N+2.
- Throughput: 1 message per 17 cycles at full input rate.
- `in_valid` low stalls collection at any byte with no state loss.
- `full` rising while in EMIT: no write; remain in EMIT. `full` falling: write in that same cycle.
- `full` is ignored outside EMIT.
- Reset assertion mid-message or in EMIT discards the partial or pending message. No `write_en` is issued. The next byte after reset release is b0.
- `in_ready` and `write_en` are never both high.

## Structure

- `parser_defs.sv` holds:
  - `parsed_msg_t`, field order msg_type, symbol[7:0], order_id[31:0], side, price[31:0], quantity[31:0], checksum[7:0];
  - the msg_type and side enums;
  - wire-code constants (`WIRE_ADD`=8'h41, `WIRE_CANCEL`, `WIRE_EXECUTE`, `WIRE_DELETE`, `WIRE_BID`=8'h42, `WIRE_ASK`=8'h53);
  - `MSG_BYTES`=16.
- One sub-module, `wire_decode`: combinational byte→enum mapping with a valid flag, shared by the type and side checks.
- Remaining logic (FSM, byte index, field registers, XOR accumulator, counter) is flat in `itch_msg_parser`.

## Test plan

- **Valid ADD bid.** Stream ADD, symbol 0x01, id 0x11111111, 'B', price 1000, quantity 10, correct checksum, `full`=0 → one `write_en` one cycle after b15, with fields {MSG_ADD, 8'h01, 32'h11111111, ORDER_SIDE_BID, 1000, 10, checksum}.
- **Backpressure.** Valid ASK message (id 0xAAAAAAAA, price 1100, quantity 15), with `full`=1 for 5 cycles from the end of b15 → `in_ready`=0 and `parsed_message` stable for those 5 cycles. Exactly one `write_en`, in the cycle `full` drops.
- **Bad checksum.** Valid fields with b15 XOR 0x01 → no `write_en`, `err_count` 0→1. An immediately following valid message is written correctly.
- **Bad side and bad type.** Side byte 0x5A, then type byte 0x7F → no writes, `err_count`=2.
- **Gapped input, back-to-back messages.** `in_valid` randomly low (50%) across three valid messages → three writes, in order, fields exact.
- **Reset mid-message.** Assert `reset` low after byte 7, release, then send a full valid message → only the second message is written. All outputs are at their reset values during reset.
